// File: rtl/cache_refill_unit_if.sv
// Bundle of cache-side and memory-side signals used by the refill engine.
// The slave modport is the refill unit's view; master is the environment's view.
interface cache_refill_unit_if #(
  parameter int BLOCK_WORDS = 8
);
  localparam int WIDX = $clog2(BLOCK_WORDS);

  logic            miss_req;
  logic [31:0]     miss_addr;
  logic            victim_dirty;
  logic [31:0]     victim_addr;
  logic [31:0]     victim_data;
  logic [WIDX-1:0] victim_idx;
  logic            fill_we;
  logic [WIDX-1:0] fill_idx;
  logic [31:0]     fill_data;
  logic            refill_done;
  logic            busy;
  logic            mem_read;
  logic            mem_write;
  logic [31:0]     mem_address;
  logic [31:0]     mem_writedata;
  logic [31:0]     mem_readdata;
  logic            mem_ready;

  modport slave (
    input  miss_req, miss_addr, victim_dirty, victim_addr, victim_data,
           mem_readdata, mem_ready,
    output victim_idx, fill_we, fill_idx, fill_data, refill_done, busy,
           mem_read, mem_write, mem_address, mem_writedata
  );

  modport master (
    output miss_req, miss_addr, victim_dirty, victim_addr, victim_data,
           mem_readdata, mem_ready,
    input  victim_idx, fill_we, fill_idx, fill_data, refill_done, busy,
           mem_read, mem_write, mem_address, mem_writedata
  );
endinterface

// File: rtl/cache_refill_unit.sv
// Miss handler: optional write-back of the dirty victim block, then an
// ascending word-by-word fetch of the missing block streamed into the fill port.
module cache_refill_unit #(
  parameter int BLOCK_WORDS = 8
) (
  input logic                 clk,
  input logic                 reset,
  cache_refill_unit_if.slave  bus
);
  localparam int WIDX = $clog2(BLOCK_WORDS);
  localparam int TAGW = 32 - WIDX - 2;

  typedef enum logic [1:0] {IDLE, WB, RD, DONE} state_t;

  state_t          state_q;
  logic [WIDX-1:0] cnt_q;
  logic [TAGW-1:0] fill_base_q;
  logic [TAGW-1:0] victim_base_q;
  logic [WIDX-1:0] victim_idx_q;
  logic            fill_we_q;
  logic [WIDX-1:0] fill_idx_q;
  logic [31:0]     fill_data_q;
  logic            refill_done_q;
  logic            busy_q;
  logic            mem_read_q;
  logic            mem_write_q;
  logic [31:0]     mem_address_q;

  logic [WIDX-1:0] cnt_inc;
  logic            cnt_last;
  logic            unused_addr_bits;

  assign cnt_inc  = cnt_q + 1'b1;
  assign cnt_last = (cnt_q == WIDX'(BLOCK_WORDS - 1));
  assign unused_addr_bits = ^{bus.miss_addr[WIDX+1:0], bus.victim_addr[WIDX+1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      fill_base_q   <= '0;
      victim_base_q <= '0;
      victim_idx_q  <= '0;
      fill_we_q     <= 1'b0;
      fill_idx_q    <= '0;
      fill_data_q   <= '0;
      refill_done_q <= 1'b0;
      busy_q        <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          fill_we_q     <= 1'b0;
          refill_done_q <= 1'b0;
          if (bus.miss_req) begin
            fill_base_q   <= bus.miss_addr[31:WIDX+2];
            victim_base_q <= bus.victim_addr[31:WIDX+2];
            cnt_q         <= '0;
            victim_idx_q  <= '0;
            busy_q        <= 1'b1;
            if (bus.victim_dirty) begin
              state_q       <= WB;
              mem_write_q   <= 1'b1;
              mem_address_q <= {bus.victim_addr[31:WIDX+2], {WIDX{1'b0}}, 2'b00};
            end else begin
              state_q       <= RD;
              mem_read_q    <= 1'b1;
              mem_address_q <= {bus.miss_addr[31:WIDX+2], {WIDX{1'b0}}, 2'b00};
            end
          end
        end
        WB: begin
          if (bus.mem_ready) begin
            if (cnt_last) begin
              state_q       <= RD;
              cnt_q         <= '0;
              victim_idx_q  <= '0;
              mem_write_q   <= 1'b0;
              mem_read_q    <= 1'b1;
              mem_address_q <= {fill_base_q, {WIDX{1'b0}}, 2'b00};
            end else begin
              cnt_q         <= cnt_inc;
              victim_idx_q  <= cnt_inc;
              mem_address_q <= {victim_base_q, cnt_inc, 2'b00};
            end
          end
        end
        RD: begin
          fill_we_q <= bus.mem_ready;
          if (bus.mem_ready) begin
            fill_data_q <= bus.mem_readdata;
            fill_idx_q  <= cnt_q;
            if (cnt_last) begin
              state_q       <= DONE;
              cnt_q         <= '0;
              mem_read_q    <= 1'b0;
              mem_address_q <= '0;
              refill_done_q <= 1'b1;
            end else begin
              cnt_q         <= cnt_inc;
              mem_address_q <= {fill_base_q, cnt_inc, 2'b00};
            end
          end
        end
        DONE: begin
          // Last fill word and completion pulse share this cycle; both drop here.
          state_q       <= IDLE;
          fill_we_q     <= 1'b0;
          refill_done_q <= 1'b0;
          busy_q        <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.victim_idx    = victim_idx_q;
  assign bus.fill_we       = fill_we_q;
  assign bus.fill_idx      = fill_idx_q;
  assign bus.fill_data     = fill_data_q;
  assign bus.refill_done   = refill_done_q;
  assign bus.busy          = busy_q;
  assign bus.mem_read      = mem_read_q;
  assign bus.mem_write     = mem_write_q;
  assign bus.mem_address   = mem_address_q;
  // Victim data is a combinational read of the cache arrays at victim_idx.
  assign bus.mem_writedata = mem_write_q ? bus.victim_data : 32'h0;
endmodule

// File: tb/tb_cache_refill_unit.sv
// Self-checking bench for cache_refill_unit: a vector table, randomized misses
// against a transfer-list scoreboard, and hand sequences for reset and held requests.
module tb_cache_refill_unit;
  localparam int BW = 8;

  logic clk;
  logic reset;
  int   total;
  int   passed;

  cache_refill_unit_if #(.BLOCK_WORDS(BW)) bus ();

  cache_refill_unit #(.BLOCK_WORDS(BW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.victim_data  = 32'hD000_0000 + 32'(bus.victim_idx);
  assign bus.mem_readdata = 32'hA000_0000 + bus.mem_address;

  typedef struct {
    logic [31:0] missAddr;
    logic        dirty;
    logic [31:0] victimAddr;
    int          mode;
    int          expDone;
  } vec_t;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic req, input logic [31:0] addr,
                               input logic dirty, input logic [31:0] vaddr);
    bus.miss_req     = req;
    bus.miss_addr    = addr;
    bus.victim_dirty = dirty;
    bus.victim_addr  = vaddr;
  endtask

  // mode 0: memory always ready, 1: ready every third cycle, 2: random ready
  task automatic runMiss(input logic [31:0] addr, input logic dirty,
                         input logic [31:0] vaddr, input int mode,
                         input int expDone, input bit hold);
    logic [31:0] expWrA[$];
    logic [31:0] expWrD[$];
    logic [31:0] expRdA[$];
    logic [31:0] expFI[$];
    logic [31:0] expFD[$];
    logic [31:0] mask;
    logic [31:0] prevA;
    logic [31:0] prevD;
    logic [31:0] a;
    logic        prevW;
    bit          prevPend;
    bit          prevAcc;
    bit          prevRdAcc;
    bit          ready;
    int          cyc;
    int          doneCyc;

    mask = ~32'(BW * 4 - 1);
    for (int i = 0; i < BW; i++) begin
      if (dirty) begin
        expWrA.push_back((vaddr & mask) + 32'(4 * i));
        expWrD.push_back(32'hD000_0000 + 32'(i));
      end
      expRdA.push_back((addr & mask) + 32'(4 * i));
      expFI.push_back(32'(i));
      expFD.push_back(32'hA000_0000 + (addr & mask) + 32'(4 * i));
    end

    @(negedge clk);
    applyStimulus(1'b1, addr, dirty, vaddr);
    bus.mem_ready = 1'b0;
    checkOutput("idle_busy", bus.busy, 0);
    @(posedge clk);
    cyc = 0; doneCyc = 0;
    prevPend = 0; prevAcc = 0; prevRdAcc = 0; prevW = 0; prevA = 0; prevD = 0;
    while (doneCyc == 0 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (!hold) bus.miss_req = 1'b0;
      case (mode)
        0:       ready = 1'b1;
        1:       ready = (cyc % 3 == 0);
        default: ready = 1'($urandom_range(0, 1));
      endcase
      bus.mem_ready = ready;
      checkOutput("busy_high", bus.busy, 1);
      checkOutput("rd_wr_exclusive", bus.mem_read & bus.mem_write, 0);
      checkOutput("fill_we_timing", bus.fill_we, prevRdAcc);
      if (bus.fill_we) begin
        if (expFI.size() == 0) checkOutput("unexpected_fill", 1, 0);
        else begin
          checkOutput("fill_idx", bus.fill_idx, expFI.pop_front());
          checkOutput("fill_data", bus.fill_data, expFD.pop_front());
        end
      end
      if (prevPend && !prevAcc && (bus.mem_read || bus.mem_write) && bus.mem_write == prevW) begin
        checkOutput("wait_addr_stable", bus.mem_address, prevA);
        if (bus.mem_write) checkOutput("wait_data_stable", bus.mem_writedata, prevD);
      end
      if (bus.mem_write && ready) begin
        if (expWrA.size() == 0) checkOutput("unexpected_write", 1, 0);
        else begin
          checkOutput("wr_addr", bus.mem_address, expWrA.pop_front());
          checkOutput("wr_data", bus.mem_writedata, expWrD.pop_front());
        end
      end
      if (bus.mem_read && ready) begin
        if (expRdA.size() == 0) checkOutput("unexpected_read", 1, 0);
        else begin
          a = expRdA.pop_front();
          checkOutput("rd_addr", bus.mem_address, a);
        end
      end
      prevRdAcc = bus.mem_read && ready;
      prevPend  = bus.mem_read || bus.mem_write;
      prevAcc   = prevPend && ready;
      prevW     = bus.mem_write;
      prevA     = bus.mem_address;
      prevD     = bus.mem_writedata;
      if (bus.refill_done) begin
        doneCyc = cyc;
        checkOutput("done_no_read", bus.mem_read, 0);
      end
    end
    checkOutput("done_seen", 32'(doneCyc != 0), 1);
    if (expDone != 0) checkOutput("done_cycle", doneCyc, expDone);
    checkOutput("writes_left", expWrA.size(), 0);
    checkOutput("reads_left", expRdA.size(), 0);
    checkOutput("fills_left", expFI.size(), 0);
    if (!hold) begin
      @(negedge clk);
      checkOutput("after_busy", bus.busy, 0);
      checkOutput("after_fill_we", bus.fill_we, 0);
      checkOutput("after_done", bus.refill_done, 0);
      checkOutput("after_read", bus.mem_read, 0);
    end
  endtask

  initial begin
    vec_t vecs[5];
    int   doneCount;
    int   budget;
    logic [31:0] ra;
    logic [31:0] rv;
    logic        rd;
    int          rm;

    total = 0;
    passed = 0;
    vecs[0] = '{32'h0000_1234, 1'b0, 32'h0000_0000, 0, BW + 1};
    vecs[1] = '{32'h0000_1234, 1'b1, 32'h0000_4020, 0, 2 * BW + 1};
    vecs[2] = '{32'hFFFF_FFFC, 1'b0, 32'h0000_0000, 0, BW + 1};
    vecs[3] = '{32'h0000_5678, 1'b1, 32'h0000_9000, 1, 0};
    vecs[4] = '{32'h00AB_CDEF, 1'b0, 32'h0000_0000, 2, 0};

    reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    bus.mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_fill_we", bus.fill_we, 0);
    checkOutput("rst_done", bus.refill_done, 0);
    checkOutput("rst_read", bus.mem_read, 0);
    checkOutput("rst_write", bus.mem_write, 0);
    checkOutput("rst_addr", bus.mem_address, 0);
    checkOutput("rst_wdata", bus.mem_writedata, 0);
    checkOutput("rst_fill_idx", bus.fill_idx, 0);
    checkOutput("rst_fill_data", bus.fill_data, 0);
    checkOutput("rst_victim_idx", bus.victim_idx, 0);
    reset = 1'b0;

    for (int v = 0; v < 5; v++)
      runMiss(vecs[v].missAddr, vecs[v].dirty, vecs[v].victimAddr,
              vecs[v].mode, vecs[v].expDone, 1'b0);

    // Reset in the middle of a fetch, then a fresh refill from word 0
    @(negedge clk);
    applyStimulus(1'b1, 32'h0000_1234, 1'b0, 32'h0);
    bus.mem_ready = 1'b1;
    @(posedge clk);
    repeat (4) begin
      @(negedge clk);
      bus.miss_req = 1'b0;
    end
    checkOutput("pre_reset_fill_idx", bus.fill_idx, 2);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midrst_busy", bus.busy, 0);
    checkOutput("midrst_read", bus.mem_read, 0);
    checkOutput("midrst_fill_we", bus.fill_we, 0);
    checkOutput("midrst_done", bus.refill_done, 0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("postrst_fill_we", bus.fill_we, 0);
    checkOutput("postrst_done", bus.refill_done, 0);
    runMiss(32'h0000_1234, 1'b0, 32'h0, 0, BW + 1, 1'b0);

    // miss_req held high: one refill, idle cycle, then the next refill
    runMiss(32'h0000_2000, 1'b0, 32'h0, 0, BW + 1, 1'b1);
    @(negedge clk);
    checkOutput("hold_idle_busy", bus.busy, 0);
    checkOutput("hold_idle_read", bus.mem_read, 0);
    @(negedge clk);
    checkOutput("hold_restart_busy", bus.busy, 1);
    checkOutput("hold_restart_read", bus.mem_read, 1);
    checkOutput("hold_restart_addr", bus.mem_address, 32'h0000_2000);
    bus.miss_req = 1'b0;
    doneCount = 0;
    budget = 0;
    while (bus.busy && budget < 100) begin
      @(negedge clk);
      budget++;
      if (bus.refill_done) doneCount++;
    end
    checkOutput("hold_second_done_count", doneCount, 1);
    checkOutput("hold_second_idle", bus.busy, 0);

    for (int r = 0; r < 12; r++) begin
      ra = $urandom;
      rv = $urandom;
      rd = 1'($urandom_range(0, 1));
      rm = $urandom_range(0, 2);
      runMiss(ra, rd, rv, rm, (rm == 0) ? (rd ? 2 * BW + 1 : BW + 1) : 0, 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
